// File: rtl/tdm_pkg.sv
// Shared constants and helpers for the DT-side TDM frame master.
// Frame layout: 65 c4 periods (slots 0..64). Slot 0 carries the f0 sync,
// slots 1..64 map to converter counter values 0..63.
package tdm_pkg;

    localparam int BITS_PER_WORD   = 32;
    localparam int SLOTS_PER_FRAME = 65;
    localparam int SLOT_W          = 7;

    typedef logic [SLOT_W-1:0] slot_t;

    localparam slot_t F0_SLOT      = 7'd0;
    localparam slot_t LAST_RX_SLOT = 7'd63;
    localparam slot_t LAST_SLOT    = slot_t'(SLOTS_PER_FRAME - 1);

    // Slot counter successor with wrap from the last slot back to slot 0.
    function automatic slot_t next_slot(input slot_t s);
        slot_t n;
        if (s == LAST_SLOT) begin
            n = F0_SLOT;
        end else begin
            n = s + 7'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/tdm_clk_gen.sv
// c4 bit-clock generator.
// Divides clk_i by 2*C4_HALF_DIV. rise_evt_o / fall_evt_o are one-cycle
// strobes registered together with c4_o, so they are high in exactly the
// clk_i cycle in which c4_o has just changed to 1 / to 0.
// Ports:
//   clk_i       system clock
//   reset_i     synchronous active-high reset
//   enable_i    run; low holds phase and c4 at 0
//   c4_o        generated bit clock
//   rise_evt_o  strobe: c4 just went 0->1
//   fall_evt_o  strobe: c4 just went 1->0
module tdm_clk_gen #(
    parameter int C4_HALF_DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic enable_i,
    output logic c4_o,
    output logic rise_evt_o,
    output logic fall_evt_o
);

    localparam int PW = $clog2(C4_HALF_DIV);
    localparam logic [PW-1:0] PHASE_LAST = PW'(C4_HALF_DIV - 1);

    logic [PW-1:0] phase_q, phase_d;
    logic          c4_q, c4_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Next-state logic for the phase counter, c4 and the edge strobes.
    always_comb begin
        phase_d = phase_q;
        c4_d    = c4_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (!enable_i) begin
            phase_d = '0;
            c4_d    = 1'b0;
        end else if (phase_q == PHASE_LAST) begin
            phase_d = '0;
            c4_d    = ~c4_q;
            rise_d  = ~c4_q;
            fall_d  = c4_q;
        end else begin
            phase_d = phase_q + PW'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q <= '0;
            c4_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            c4_q    <= c4_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign c4_o       = c4_q;
    assign rise_evt_o = rise_q;
    assign fall_evt_o = fall_q;

endmodule

// File: rtl/tdm_frame_master.sv
// DT-side master for the converter TDM link.
// Generates c4 and active-low f0, serialises one 32-bit word per frame
// LSB first on tdm_tx (bit j driven at the fall of slot 2j, so it is stable
// across converter rises c=2j and c=2j+1) and deserialises tdm_rx (bit j
// sampled at the fall of slot 2j+1). All DT-facing outputs are registered.
// Ports:
//   clk50, reset        system clock, synchronous active-high reset
//   enable              run; low idles the link and aborts a frame
//   tx_data/tx_valid    word offered for the next frame
//   tx_ready            pulse: tx_data was captured (cycle after capture edge)
//   tx_underrun         pulse: IDLE_WORD loaded because nothing was offered
//   rx_data/rx_valid    last received word / pulse when it updates
//   frame_start         pulse following the slot-0 rise
//   buf_done            pulse with rx_valid of the last word of a buffer
//   c4, f0, tdm_tx      link outputs toward the converter
//   tdm_rx              serial data from the converter
module tdm_frame_master
    import tdm_pkg::*;
#(
    parameter int                 C4_HALF_DIV = 4,
    parameter int                 NUM_WORDS   = 2,
    parameter logic [BITS_PER_WORD-1:0] IDLE_WORD = 32'h0000_0000
) (
    input  logic                     clk50,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [BITS_PER_WORD-1:0] tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic                     tx_underrun,
    output logic [BITS_PER_WORD-1:0] rx_data,
    output logic                     rx_valid,
    output logic                     frame_start,
    output logic                     buf_done,
    output logic                     c4,
    output logic                     f0,
    output logic                     tdm_tx,
    input  logic                     tdm_rx
);

    localparam int WIW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [WIW-1:0] WORD_LAST = WIW'(NUM_WORDS - 1);

    logic rise_evt_s;
    logic fall_evt_s;

    tdm_clk_gen #(
        .C4_HALF_DIV (C4_HALF_DIV)
    ) u_clk_gen (
        .clk_i      (clk50),
        .reset_i    (reset),
        .enable_i   (enable),
        .c4_o       (c4),
        .rise_evt_o (rise_evt_s),
        .fall_evt_o (fall_evt_s)
    );

    logic                     en_q, en_d;
    logic                     started_q, started_d;
    slot_t                    slot_q, slot_d;
    logic [WIW-1:0]           word_idx_q, word_idx_d;
    logic                     f0_q, f0_d;
    logic                     tdm_tx_q, tdm_tx_d;
    logic [BITS_PER_WORD-1:0] tx_word_q, tx_word_d;
    logic [BITS_PER_WORD-1:0] rx_sr_q, rx_sr_d;
    logic [BITS_PER_WORD-1:0] rx_data_q, rx_data_d;
    logic                     tx_ready_q, tx_ready_d;
    logic                     tx_underrun_q, tx_underrun_d;
    logic                     rx_valid_q, rx_valid_d;
    logic                     frame_start_q, frame_start_d;
    logic                     buf_done_q, buf_done_d;

    // Even slot 2j and odd slot 2j+1 both address bit j.
    logic [4:0] bit_idx_s;
    assign bit_idx_s = slot_q[5:1];

    // Frame sequencing: slot tracking on rises, tx/rx/f0 activity on falls.
    always_comb begin
        en_d          = enable;
        started_d     = started_q;
        slot_d        = slot_q;
        word_idx_d    = word_idx_q;
        f0_d          = f0_q;
        tdm_tx_d      = tdm_tx_q;
        tx_word_d     = tx_word_q;
        rx_sr_d       = rx_sr_q;
        rx_data_d     = rx_data_q;
        tx_ready_d    = 1'b0;
        tx_underrun_d = 1'b0;
        rx_valid_d    = 1'b0;
        frame_start_d = 1'b0;
        buf_done_d    = 1'b0;
        if (!enable) begin
            started_d = 1'b0;
            slot_d    = F0_SLOT;
            f0_d      = 1'b1;
            tdm_tx_d  = 1'b0;
            rx_sr_d   = '0;
        end else if (!en_q) begin
            // Start of a run: pull f0 low now so the very first c4 rise is
            // the slot-0 rise with f0 asserted.
            started_d  = 1'b0;
            slot_d     = F0_SLOT;
            word_idx_d = '0;
            f0_d       = 1'b0;
            rx_sr_d    = '0;
        end else if (rise_evt_s) begin
            // The first rise of a run is slot 0 itself, so it does not advance.
            started_d = 1'b1;
            if (started_q) begin
                slot_d        = next_slot(slot_q);
                frame_start_d = (slot_q == LAST_SLOT);
            end else begin
                slot_d        = F0_SLOT;
                frame_start_d = 1'b1;
            end
        end else if (fall_evt_s) begin
            if (slot_q == F0_SLOT) begin
                f0_d = 1'b1;
                if (tx_valid) begin
                    tx_word_d  = tx_data;
                    tx_ready_d = 1'b1;
                end else begin
                    tx_word_d     = IDLE_WORD;
                    tx_underrun_d = 1'b1;
                end
                tdm_tx_d = tx_word_d[0];
            end else if (slot_q == LAST_SLOT) begin
                f0_d = 1'b0;
            end else if (!slot_q[0]) begin
                tdm_tx_d = tx_word_q[bit_idx_s];
            end else begin
                rx_sr_d[bit_idx_s] = tdm_rx;
                if (slot_q == LAST_RX_SLOT) begin
                    rx_data_d  = rx_sr_d;
                    rx_valid_d = 1'b1;
                    buf_done_d = (word_idx_q == WORD_LAST);
                    if (word_idx_q == WORD_LAST) begin
                        word_idx_d = '0;
                    end else begin
                        word_idx_d = word_idx_q + WIW'(1);
                    end
                end else begin
                    rx_data_d = rx_data_q;
                end
            end
        end else begin
            slot_d = slot_q;
        end
    end

    // State and output registers with synchronous reset; f0 idles high.
    always_ff @(posedge clk50) begin
        if (reset) begin
            en_q          <= 1'b0;
            started_q     <= 1'b0;
            slot_q        <= F0_SLOT;
            word_idx_q    <= '0;
            f0_q          <= 1'b1;
            tdm_tx_q      <= 1'b0;
            tx_word_q     <= '0;
            rx_sr_q       <= '0;
            rx_data_q     <= '0;
            tx_ready_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            buf_done_q    <= 1'b0;
        end else begin
            en_q          <= en_d;
            started_q     <= started_d;
            slot_q        <= slot_d;
            word_idx_q    <= word_idx_d;
            f0_q          <= f0_d;
            tdm_tx_q      <= tdm_tx_d;
            tx_word_q     <= tx_word_d;
            rx_sr_q       <= rx_sr_d;
            rx_data_q     <= rx_data_d;
            tx_ready_q    <= tx_ready_d;
            tx_underrun_q <= tx_underrun_d;
            rx_valid_q    <= rx_valid_d;
            frame_start_q <= frame_start_d;
            buf_done_q    <= buf_done_d;
        end
    end

    assign f0          = f0_q;
    assign tdm_tx      = tdm_tx_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = tx_ready_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_start = frame_start_q;
    assign buf_done    = buf_done_q;

endmodule
